alu_out_stage: RTL and testbench
================================

ALU_OUT_STAGE -- requirements
Module: alu_out_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width of the result from the 4:1 mux bank.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the accepted-result counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream mux-bank result is valid.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the result selected by the 4:1 mux bank.
REQ-007 The block SHALL have port in_carry, input, 1 bit: the carry/borrow accompanying in_data.
REQ-008 The block SHALL have port in_sel, input, 2 bits: the select code S that produced in_data.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the stage can accept a result this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data, out_flags and out_sel hold a valid entry.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the entry.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: the registered result.
REQ-013 The block SHALL have port out_flags, output, 4 bits: {C,Z,N,P} for out_data.
REQ-014 The block SHALL have port out_sel, output, 2 bits: the select code stored with out_data.
REQ-015 The block SHALL have port op_count, output, CNT_W bits: the number of results accepted since reset.

Function
REQ-016 The block SHALL accept an entry when in_valid and in_ready are both 1 on a rising edge, and SHALL deliver one when out_valid and out_ready are both 1.
REQ-017 The block SHALL be a 2-entry skid buffer with states EMPTY (0 entries), ONE (1 entry) and TWO (2 entries); entries are kept in FIFO order.
REQ-018 On accept only: EMPTY->ONE, ONE->TWO; on deliver only: ONE->EMPTY, TWO->ONE.
REQ-019 Simultaneous accept and deliver in ONE SHALL stay in ONE, with the new entry replacing the delivered one.
REQ-020 in_ready SHALL be a registered output equal to 1 in EMPTY and ONE, and 0 in TWO; in_valid while in_ready is 0 SHALL be ignored, with no state change and no count.
REQ-021 out_valid SHALL be 1 in ONE and TWO; out_* SHALL always present the oldest entry and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Latency from accept in EMPTY to out_valid=1 SHALL be exactly 1 cycle; there is no combinational path from in_* to out_*, and none from out_ready to in_ready.
REQ-023 Flags SHALL be computed from in_data and stored at accept: C=in_carry; Z=1 iff in_data==0; N=in_data[WIDTH-1]; P=XOR-reduction of in_data (odd parity).
REQ-024 op_count SHALL increment by 1 on every accept and wrap from 2^CNT_W-1 to 0 with no saturation.
REQ-025 Sustained in_valid=1 with out_ready=1 SHALL give one transfer per cycle (full throughput).
REQ-026 After out_ready drops, at most one further entry SHALL be accepted (the skid slot); no entry SHALL ever be dropped or duplicated.

Reset
REQ-027 While rst=1, the state SHALL be EMPTY and in_ready, out_valid, out_data, out_flags, out_sel and op_count SHALL be 0, taking effect immediately, independent of clk.
REQ-028 Assertion of rst mid-operation SHALL discard all held entries; in_ready SHALL become 1 on the first rising edge after rst deasserts.

Verification
REQ-029 Reset, then accept in_data=8'h00, in_carry=0, in_sel=2'b01 -> the next cycle gives out_valid=1, out_data=8'h00, out_flags=4'b0100, out_sel=2'b01, op_count=1.
REQ-030 Accept 8'h83 with carry=1 -> out_flags=4'b1011 (C=1, Z=0, N=1, P=1).
REQ-031 With out_ready=0, offer 8'h11, 8'h22, 8'h33 back-to-back -> only 8'h11 and 8'h22 are accepted and in_ready=0; after raising out_ready, out_data=8'h11 then 8'h22; op_count=2.
REQ-032 Stream 100 results with out_ready=1 continuously -> 100 outputs in order, one per cycle, and op_count=100.
REQ-033 Preload op_count to 16'hFFFF by 65535 accepts, then accept one more -> op_count=16'h0000.
REQ-034 Assert rst asynchronously between edges while in TWO -> out_valid=0, in_ready=0 and op_count=0 immediately; in_ready=1 one edge after release.

Source files
------------

// File: rtl/alu_out_stage.sv
// Output stage for the ALU mux bank: a 2-entry skid buffer that registers the
// selected result along with its {C,Z,N,P} flags, and counts accepted results.
module alu_out_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_carry,
  input  logic [1:0]       in_sel,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_flags,
  output logic [1:0]       out_sel,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic [3:0]       head_flags_q, head_flags_d;
  logic [1:0]       head_sel_q, head_sel_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [3:0]       skid_flags_q, skid_flags_d;
  logic [1:0]       skid_sel_q, skid_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       accept;
  logic       deliver;
  logic [3:0] new_flags;

  always_comb begin
    accept    = in_valid & in_ready_q;
    deliver   = (state_q != EMPTY) & out_ready;
    new_flags = {in_carry, (in_data == '0), in_data[WIDTH-1], ^in_data};
  end

  // Head is always the oldest entry and drives out_*; skid holds the second.
  always_comb begin
    state_d      = state_q;
    head_data_d  = head_data_q;
    head_flags_d = head_flags_q;
    head_sel_d   = head_sel_q;
    skid_data_d  = skid_data_q;
    skid_flags_d = skid_flags_q;
    skid_sel_d   = skid_sel_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          head_data_d  = in_data;
          head_flags_d = new_flags;
          head_sel_d   = in_sel;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          head_data_d  = in_data;
          head_flags_d = new_flags;
          head_sel_d   = in_sel;
        end else if (accept) begin
          skid_data_d  = in_data;
          skid_flags_d = new_flags;
          skid_sel_d   = in_sel;
          state_d      = TWO;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (deliver) begin
          head_data_d  = skid_data_q;
          head_flags_d = skid_flags_q;
          head_sel_d   = skid_sel_q;
          state_d      = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Registered ready looks ahead at the next occupancy, so it never
    // depends combinationally on out_ready.
    in_ready_d = (state_d != TWO);
    cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, accept};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b0;
      head_data_q  <= '0;
      head_flags_q <= '0;
      head_sel_q   <= '0;
      skid_data_q  <= '0;
      skid_flags_q <= '0;
      skid_sel_q   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      head_data_q  <= head_data_d;
      head_flags_q <= head_flags_d;
      head_sel_q   <= head_sel_d;
      skid_data_q  <= skid_data_d;
      skid_flags_q <= skid_flags_d;
      skid_sel_q   <= skid_sel_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = (state_q != EMPTY);
    out_data  = head_data_q;
    out_flags = head_flags_q;
    out_sel   = head_sel_q;
    op_count  = cnt_q;
  end

endmodule

// File: tb/tb_alu_out_stage.sv
// Self-checking bench for alu_out_stage: a queue-based FIFO model with an
// occupancy-driven ready predicts every output.
module tb_alu_out_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_carry = 1'b0;
  logic [1:0] in_sel = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [3:0] out_flags;
  logic [1:0] out_sel;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       c;
    logic [1:0] s;
  } ent_t;

  ent_t q[$];
  bit   mdl_rdy = 0;
  int   mdl_cnt = 0;

  alu_out_stage #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_carry(in_carry), .in_sel(in_sel), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .out_sel(out_sel), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_flags(ent_t e);
    logic z, n, p;
    z = (e.d == 0);
    n = (e.d >= 8'd128);
    p = ($countones(e.d) % 2) == 1;
    return {e.c, z, n, p};
  endfunction

  function automatic void mdl_reset();
    q.delete();
    mdl_rdy = 0;
    mdl_cnt = 0;
  endfunction

  // One clock edge; model advances with the inputs held across that edge.
  task automatic tick();
    bit acc, del;
    @(posedge clk);
    if (rst) begin
      mdl_reset();
    end else begin
      acc = in_valid && mdl_rdy;
      del = out_ready && (q.size() > 0);
      if (del) void'(q.pop_front());
      if (acc) begin
        q.push_back('{d: in_data, c: in_carry, s: in_sel});
        mdl_cnt = (mdl_cnt + 1) % 65536;
      end
      mdl_rdy = (q.size() < 2);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
        out_flags !== 4'h0 || out_sel !== 2'b00 || op_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b data=%h flags=%b sel=%b cnt=%h, required all zero",
               in_ready, out_valid, out_data, out_flags, out_sel, op_count);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b vld=%b, required rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_flags();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h00; in_carry = 1'b0; in_sel = 2'b01;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h00 || out_flags !== 4'b0100 ||
        out_sel !== 2'b01 || op_count !== 16'd1) begin
      errors++;
      $display("FAIL zero_entry: vld=%b data=%h flags=%b sel=%b cnt=%0d, required 1 00 0100 01 1",
               out_valid, out_data, out_flags, out_sel, op_count);
    end
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h83; in_carry = 1'b1; in_sel = 2'b10;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h83 || out_flags !== 4'b1011 || out_sel !== 2'b10) begin
      errors++;
      $display("FAIL flags_83: vld=%b data=%h flags=%b sel=%b, required 1 83 1011 10",
               out_valid, out_data, out_flags, out_sel);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_single: vld=%b, required 0", out_valid);
    end
  endtask

  task automatic test_skid();
    logic [7:0] vals [3];
    logic       rdy_exp [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    rdy_exp[0] = 1'b1; rdy_exp[1] = 1'b0; rdy_exp[2] = 1'b0;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i]; in_carry = 1'b0; in_sel = 2'(i);
      tick();
      checks++;
      if (in_ready !== rdy_exp[i] || out_data !== 8'h11) begin
        errors++;
        $display("FAIL skid_fill_%0d: rdy=%b data=%h, required rdy=%b data=11",
                 i, in_ready, out_data, rdy_exp[i]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22 || op_count !== 16'd2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_drain: vld=%b data=%h cnt=%0d rdy=%b, required 1 22 2 1",
               out_valid, out_data, op_count, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || op_count !== 16'd2) begin
      errors++;
      $display("FAIL skid_empty: vld=%b cnt=%0d, required 0 2", out_valid, op_count);
    end
  endtask

  task automatic test_stream();
    int got = 0;
    int nxt = 0;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'(nxt); in_carry = 1'b0; in_sel = 2'(nxt);
    for (int cyc = 0; cyc < 110 && got < 100; cyc++) begin
      tick();
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== 8'(got) || out_sel !== 2'(got)) begin
          errors++;
          $display("FAIL stream_order: data=%h sel=%b, required %h %b",
                   out_data, out_sel, 8'(got), 2'(got));
        end
        got++;
      end
      if (in_ready === 1'b1 && in_valid && mdl_cnt > nxt) nxt++;
      if (nxt >= 100) in_valid = 1'b0;
      in_data = 8'(nxt); in_sel = 2'(nxt);
    end
    checks++;
    if (got !== 100 || op_count !== 16'd100) begin
      errors++;
      $display("FAIL stream_total: outputs=%0d cnt=%0d, required 100 100", got, op_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_carry  = 1'($urandom);
      in_sel    = 2'($urandom);
      tick();
      checks++;
      if (in_ready !== mdl_rdy || out_valid !== (q.size() > 0) || op_count !== 16'(mdl_cnt) ||
          (q.size() > 0 && (out_data !== q[0].d || out_flags !== exp_flags(q[0]) || out_sel !== q[0].s))) begin
        errors++;
        $display("FAIL random_cyc%0d: rdy=%b vld=%b data=%h flags=%b sel=%b cnt=%0d, required rdy=%b vld=%b cnt=%0d head=%h/%b/%b",
                 cyc, in_ready, out_valid, out_data, out_flags, out_sel, op_count,
                 mdl_rdy, q.size() > 0, mdl_cnt,
                 q.size() > 0 ? q[0].d : 8'h0, q.size() > 0 ? exp_flags(q[0]) : 4'h0,
                 q.size() > 0 ? q[0].s : 2'b0);
      end
    end
  endtask

  task automatic test_wrap();
    int budget = 70000;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    while (mdl_cnt != 65535 && budget > 0) begin
      in_data = 8'($urandom);
      tick();
      budget--;
    end
    checks++;
    if (op_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: cnt=%h, required ffff (budget left %0d)", op_count, budget);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (op_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_rollover: cnt=%h, required 0000", op_count);
    end
  endtask

  task automatic test_reset_in_two();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hA5;
    tick();
    in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || op_count !== 16'd2) begin
      errors++;
      $display("FAIL two_setup: vld=%b rdy=%b cnt=%0d, required 1 0 2", out_valid, in_ready, op_count);
    end
    #2 rst = 1'b1;
    #1;
    mdl_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || op_count !== 16'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: vld=%b rdy=%b cnt=%0d data=%h, required 0 0 0 00",
               out_valid, in_ready, op_count, out_data);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: rdy=%b, required 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_flags();
    test_skid();
    test_stream();
    test_random();
    test_reset_in_two();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
